// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: wait-state-aware memory controller between the CPU data bus
// and the ROM / I/O / RAM blocks. Decodes each request against three
// base/size regions, drives a one-hot select for WS+1 cycles, then returns
// a one-cycle registered response.
//
// Build option: define MEMCTRL_BUS_ERR_EN to flag unmapped accesses and ROM
// writes with bus_err. Without it (legacy), bus_err stays 0, unmapped reads
// return 0, unmapped writes are acknowledged and ROM writes go through.
//
// state    | meaning
// S_IDLE   | ready=1, waiting for req
// S_ACCESS | region select held, wait counter running
// S_RESP   | resp_valid strobe, data_out/bus_err presented
module mem_ctrl_ws #(
  parameter int            AW        = 16,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] ROM_BASE  = 16'h0000,
  parameter int            ROM_WORDS = 32,
  parameter logic [AW-1:0] IO_BASE   = 16'h0020,
  parameter int            IO_WORDS  = 32,
  parameter logic [AW-1:0] RAM_BASE  = 16'h0800,
  parameter int            RAM_WORDS = 2048,
  parameter int            ROM_WS    = 0,
  parameter int            IO_WS     = 1,
  parameter int            RAM_WS    = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  output logic          ready,
  output logic          resp_valid,
  output logic [DW-1:0] data_out,
  output logic          bus_err,
  output logic          rom_sel,
  output logic          io_sel,
  output logic          ram_sel,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] rom_rdata,
  input  logic [DW-1:0] io_rdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

`ifdef MEMCTRL_BUS_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Region bounds widened by one bit so the subtract-and-compare hit test
  // cannot wrap into range when the address is below the base.
  localparam logic [AW:0] ROM_BASE_X = {1'b0, ROM_BASE};
  localparam logic [AW:0] IO_BASE_X  = {1'b0, IO_BASE};
  localparam logic [AW:0] RAM_BASE_X = {1'b0, RAM_BASE};
  localparam logic [AW:0] ROM_SIZE_X = (AW+1)'(ROM_WORDS);
  localparam logic [AW:0] IO_SIZE_X  = (AW+1)'(IO_WORDS);
  localparam logic [AW:0] RAM_SIZE_X = (AW+1)'(RAM_WORDS);
  localparam logic [AW-1:0] ROM_MASK = AW'(ROM_WORDS - 1);
  localparam logic [AW-1:0] IO_MASK  = AW'(IO_WORDS - 1);
  localparam logic [AW-1:0] RAM_MASK = AW'(RAM_WORDS - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [2:0]    region_q;   // {ram, io, rom}
  logic          err_q;

  logic [AW:0]   addr_x;
  logic          rom_hit, io_hit, ram_hit;
  logic [2:0]    dec_region;
  logic [3:0]    dec_ws;
  logic [AW-1:0] dec_off;
  logic [DW-1:0] rdata_mux;

  assign addr_x  = {1'b0, address};
  assign rom_hit = (addr_x - ROM_BASE_X) < ROM_SIZE_X;
  assign io_hit  = (addr_x - IO_BASE_X)  < IO_SIZE_X;
  assign ram_hit = (addr_x - RAM_BASE_X) < RAM_SIZE_X;

  // Region decode with ROM > IO > RAM priority; a blocked ROM write or a miss
  // leaves dec_region empty so the request goes straight to RESP.
  always_comb begin
    dec_region = 3'b000;
    dec_ws     = 4'd0;
    dec_off    = '0;
    if (rom_hit) begin
      if (!(ERR_EN && we)) begin
        dec_region = 3'b001;
        dec_ws     = 4'(ROM_WS);
        dec_off    = address & ROM_MASK;
      end
    end else if (io_hit) begin
      dec_region = 3'b010;
      dec_ws     = 4'(IO_WS);
      dec_off    = address & IO_MASK;
    end else if (ram_hit) begin
      dec_region = 3'b100;
      dec_ws     = 4'(RAM_WS);
      dec_off    = address & RAM_MASK;
    end
  end

  // Read-data mux for the region currently being accessed.
  always_comb begin
    rdata_mux = '0;
    case (region_q)
      3'b001:  rdata_mux = rom_rdata;
      3'b010:  rdata_mux = io_rdata;
      3'b100:  rdata_mux = ram_rdata;
      default: rdata_mux = '0;
    endcase
  end

  // Sequencer: accept/decode, wait-state countdown, response capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      region_q  <= 3'b000;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q      <= we;
            mem_wdata <= data_in;
            region_q  <= dec_region;
            mem_addr  <= dec_off;
            if (dec_region != 3'b000) begin
              cnt   <= dec_ws;
              err_q <= 1'b0;
              state <= S_ACCESS;
            end else begin
              cnt      <= 4'd0;
              data_out <= '0;
              err_q    <= ERR_EN;
              state    <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            data_out <= we_q ? '0 : rdata_mux;
            state    <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an aborted access never writes or responds
  // in the cycle the reset is being sampled.
  assign ready      = (state == S_IDLE);
  assign resp_valid = (state == S_RESP) && !reset;
  assign mem_we     = (state == S_ACCESS) && (cnt == 4'd0) && we_q && !reset;
  assign rom_sel    = (state == S_ACCESS) && region_q[0];
  assign io_sel     = (state == S_ACCESS) && region_q[1];
  assign ram_sel    = (state == S_ACCESS) && region_q[2];
  assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_ctrl_ws.sv
// Directed bench for mem_ctrl_ws: a default instance (IO_WS=1) and a second
// instance with IO_WS=3 for the reset-abort case. Inputs change and outputs
// are sampled on the falling edge.
module tb_mem_ctrl_ws;

  logic        clock = 1'b0;
  logic        reset, req, we;
  logic [15:0] address;
  logic [31:0] data_in, rom_rdata, io_rdata, ram_rdata;

  logic        a_ready, a_resp_valid, a_bus_err, a_rom_sel, a_io_sel, a_ram_sel, a_mem_we;
  logic [31:0] a_data_out, a_mem_wdata;
  logic [15:0] a_mem_addr;
  logic        b_ready, b_resp_valid, b_bus_err, b_rom_sel, b_io_sel, b_ram_sel, b_mem_we;
  logic [31:0] b_data_out, b_mem_wdata;
  logic [15:0] b_mem_addr;

  int errors = 0;
  int checks = 0;

`ifdef MEMCTRL_BUS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  mem_ctrl_ws u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .address(address),
    .data_in(data_in), .ready(a_ready), .resp_valid(a_resp_valid),
    .data_out(a_data_out), .bus_err(a_bus_err), .rom_sel(a_rom_sel),
    .io_sel(a_io_sel), .ram_sel(a_ram_sel), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .rom_rdata(rom_rdata),
    .io_rdata(io_rdata), .ram_rdata(ram_rdata)
  );

  mem_ctrl_ws #(.IO_WS(3)) u_dut3 (
    .clock(clock), .reset(reset), .req(req), .we(we), .address(address),
    .data_in(data_in), .ready(b_ready), .resp_valid(b_resp_valid),
    .data_out(b_data_out), .bus_err(b_bus_err), .rom_sel(b_rom_sel),
    .io_sel(b_io_sel), .ram_sel(b_ram_sel), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .rom_rdata(rom_rdata),
    .io_rdata(io_rdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] bb_addr [4];
  logic [31:0] bb_data [4];
  logic [2:0]  bb_sel  [4];
  int          nresp;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; data_in = '0;
    rom_rdata = 32'hDEADBEEF; io_rdata = 32'h000000A5; ram_rdata = 32'h0BADF00D;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_resp", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_sels", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'd0);
    chk("rst_we", {31'd0, a_mem_we}, 32'd0);
    chk("rst_err", {31'd0, a_bus_err}, 32'd0);
    chk("rst_dout", a_data_out, 32'd0);
    chk("rst_addr", {16'd0, a_mem_addr}, 32'd0);
    chk("rst_wdata", a_mem_wdata, 32'd0);
    reset = 1'b0;

    // ROM read, WS=0
    @(negedge clock);
    req = 1'b1; we = 1'b0; address = 16'h0005;
    chk("rom_rd_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clock);
    chk("rom_rd_sel1", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b100);
    chk("rom_rd_addr", {16'd0, a_mem_addr}, 32'd5);
    chk("rom_rd_we", {31'd0, a_mem_we}, 32'd0);
    chk("rom_rd_resp1", {31'd0, a_resp_valid}, 32'd0);
    chk("rom_rd_busy1", {31'd0, a_ready}, 32'd0);
    req = 1'b0;
    @(negedge clock);
    chk("rom_rd_sel2", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b000);
    chk("rom_rd_resp2", {31'd0, a_resp_valid}, 32'd1);
    chk("rom_rd_data", a_data_out, 32'hDEADBEEF);
    chk("rom_rd_err", {31'd0, a_bus_err}, 32'd0);
    chk("rom_rd_busy2", {31'd0, a_ready}, 32'd0);
    @(negedge clock);
    chk("rom_rd_ready3", {31'd0, a_ready}, 32'd1);
    chk("rom_rd_resp3", {31'd0, a_resp_valid}, 32'd0);

    // RAM write, WS=0
    req = 1'b1; we = 1'b1; address = 16'h0823; data_in = 32'h12345678;
    @(negedge clock);
    chk("ram_wr_sel", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b001);
    chk("ram_wr_we", {31'd0, a_mem_we}, 32'd1);
    chk("ram_wr_addr", {16'd0, a_mem_addr}, 32'h023);
    chk("ram_wr_wdata", a_mem_wdata, 32'h12345678);
    req = 1'b0; we = 1'b0;
    @(negedge clock);
    chk("ram_wr_resp", {31'd0, a_resp_valid}, 32'd1);
    chk("ram_wr_data", a_data_out, 32'd0);
    chk("ram_wr_we2", {31'd0, a_mem_we}, 32'd0);
    chk("ram_wr_sel2", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b000);
    @(negedge clock);

    // I/O read, WS=1
    req = 1'b1; we = 1'b0; address = 16'h0021;
    @(negedge clock);
    chk("io_rd_sel1", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b010);
    chk("io_rd_addr", {16'd0, a_mem_addr}, 32'd1);
    chk("io_rd_resp1", {31'd0, a_resp_valid}, 32'd0);
    req = 1'b0;
    @(negedge clock);
    chk("io_rd_sel2", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b010);
    chk("io_rd_resp2", {31'd0, a_resp_valid}, 32'd0);
    @(negedge clock);
    chk("io_rd_resp3", {31'd0, a_resp_valid}, 32'd1);
    chk("io_rd_data", a_data_out, 32'h000000A5);
    chk("io_rd_sel3", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b000);
    @(negedge clock);

    // Unmapped read
    req = 1'b1; we = 1'b0; address = 16'h4000;
    @(negedge clock);
    chk("unm_sel", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, 32'b000);
    chk("unm_resp", {31'd0, a_resp_valid}, 32'd1);
    chk("unm_data", a_data_out, 32'd0);
    chk("unm_err", {31'd0, a_bus_err}, {31'd0, EXP_ERR});
    req = 1'b0;
    @(negedge clock);
    chk("unm_ready", {31'd0, a_ready}, 32'd1);
    chk("unm_resp2", {31'd0, a_resp_valid}, 32'd0);

    // ROM write
    req = 1'b1; we = 1'b1; address = 16'h0004; data_in = 32'h55;
    @(negedge clock);
    req = 1'b0; we = 1'b0;
`ifdef MEMCTRL_BUS_ERR_EN
    chk("romw_sel", {31'd0, a_rom_sel}, 32'd0);
    chk("romw_we", {31'd0, a_mem_we}, 32'd0);
    chk("romw_resp", {31'd0, a_resp_valid}, 32'd1);
    chk("romw_err", {31'd0, a_bus_err}, 32'd1);
    @(negedge clock);
`else
    chk("romw_sel", {31'd0, a_rom_sel}, 32'd1);
    chk("romw_we", {31'd0, a_mem_we}, 32'd1);
    chk("romw_resp1", {31'd0, a_resp_valid}, 32'd0);
    @(negedge clock);
    chk("romw_resp", {31'd0, a_resp_valid}, 32'd1);
    chk("romw_err", {31'd0, a_bus_err}, 32'd0);
    @(negedge clock);
`endif
    chk("romw_ready", {31'd0, a_ready}, 32'd1);

    // Reset abort during an I/O write with IO_WS=3
    req = 1'b1; we = 1'b1; address = 16'h0022; data_in = 32'hCAFE;
    chk("abort_ready0", {31'd0, b_ready}, 32'd1);
    @(negedge clock);
    chk("abort_sel1", {31'd0, b_io_sel}, 32'd1);
    chk("abort_we1", {31'd0, b_mem_we}, 32'd0);
    req = 1'b0; we = 1'b0;
    @(negedge clock);
    chk("abort_sel2", {31'd0, b_io_sel}, 32'd1);
    chk("abort_we2", {31'd0, b_mem_we}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_we3", {31'd0, b_mem_we}, 32'd0);
    chk("abort_resp3", {31'd0, b_resp_valid}, 32'd0);
    chk("abort_ready3", {31'd0, b_ready}, 32'd1);
    chk("abort_sel3", {31'd0, b_io_sel}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("abort_we_post", {31'd0, b_mem_we}, 32'd0);
      chk("abort_resp_post", {31'd0, b_resp_valid}, 32'd0);
    end

    // Back-to-back reads with req held high
    bb_addr[0] = 16'h0003; bb_data[0] = 32'hDEADBEEF; bb_sel[0] = 3'b100;
    bb_addr[1] = 16'h0805; bb_data[1] = 32'h0BADF00D; bb_sel[1] = 3'b001;
    bb_addr[2] = 16'h0007; bb_data[2] = 32'hDEADBEEF; bb_sel[2] = 3'b100;
    bb_addr[3] = 16'h0806; bb_data[3] = 32'h0BADF00D; bb_sel[3] = 3'b001;
    nresp = 0;
    req = 1'b1; we = 1'b0; address = bb_addr[0];
    chk("bb_ready0", {31'd0, a_ready}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      int ph, idx;
      @(negedge clock);
      ph  = k % 3;
      idx = (k - 1) / 3;
      if (a_resp_valid) nresp++;
      if (ph == 1) begin
        chk("bb_ready_acc", {31'd0, a_ready}, 32'd0);
        chk("bb_sel", {29'd0, a_rom_sel, a_io_sel, a_ram_sel}, {29'd0, bb_sel[idx]});
        chk("bb_resp_acc", {31'd0, a_resp_valid}, 32'd0);
        if (idx < 3) address = bb_addr[idx + 1];
      end else if (ph == 2) begin
        chk("bb_ready_resp", {31'd0, a_ready}, 32'd0);
        chk("bb_resp", {31'd0, a_resp_valid}, 32'd1);
        chk("bb_data", a_data_out, bb_data[idx]);
      end else begin
        chk("bb_ready_idle", {31'd0, a_ready}, 32'd1);
        chk("bb_resp_idle", {31'd0, a_resp_valid}, 32'd0);
        if (idx == 3) req = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (a_resp_valid) nresp++;
      chk("bb_tail_ready", {31'd0, a_ready}, 32'd1);
    end
    chk("bb_count", nresp, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_ws.md
# mem_ctrl_ws

Parametrised, wait-state-aware memory controller that sits between the CPU data bus and the ROM, I/O and RAM blocks. It decodes each request against three configurable base/size regions and drives a one-hot select to the chosen region for a per-region number of wait states. It returns read data or a write acknowledge through a registered response, and flags unmapped accesses. Each request takes a configurable number of cycles and follows a req/ready handshake.

## Interface
- AW, 16, address width
- DW, 32, data width
- ROM_BASE, 16'h0000, ROM region base (aligned to ROM_WORDS)
- ROM_WORDS, 32, ROM size in words, power of two
- IO_BASE, 16'h0020, I/O region base
- IO_WORDS, 32, I/O size in words, power of two
- RAM_BASE, 16'h0800, RAM region base
- RAM_WORDS, 2048, RAM size in words, power of two
- ROM_WS / IO_WS / RAM_WS, 0 / 1 / 0, wait states per region, 0..15
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- req  in  1  request valid
- we  in  1  write (1) / read (0), sampled with req
- address  in  AW  word address, sampled with req
- data_in  in  DW  write data, sampled with req
- ready  out  1  controller can accept a request
- resp_valid  out  1  one-cycle response strobe
- data_out  out  DW  read data, valid with resp_valid
- bus_err  out  1  unmapped-access flag, valid with resp_valid
- rom_sel / io_sel / ram_sel  out  1 each  one-hot region select
- mem_we  out  1  write strobe to the selected region
- mem_addr  out  AW  region-relative offset (address & (WORDS-1))
- mem_wdata  out  DW  latched write data
- rom_rdata / io_rdata / ram_rdata  in  DW each  region read data

## Operation
- Three states: IDLE, ACCESS, RESP.
- IDLE:
  - ready=1.
  - On req=1, latch address, we and data_in, then decode.
  - A mapped region goes to ACCESS with wait counter = region WS.
  - An unmapped address goes straight to RESP.
- Decode: a hit means base <= address <= base+WORDS-1. Priority on overlap is ROM > IO > RAM.
- ACCESS:
  - The selected region's *_sel is held high and mem_addr/mem_wdata are held stable.
  - The counter decrements each cycle. When the counter is 0, this is the final access cycle:
    - mem_we = latched we (for this cycle only).
    - The selected *_rdata is registered into data_out.
    - Next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Write responses: data_out=0.
  - Unmapped: data_out=0, bus_err per Configuration.
  - Returns to IDLE; ready=0 during RESP.
- req while ready=0 is ignored; the requester holds req until accepted.
- Reset values:
  - State IDLE, ready=1.
  - resp_valid, bus_err, all *_sel and mem_we are 0.
  - data_out, mem_addr and mem_wdata are 0.
  - Counter 0.
- Reset mid-operation (ACCESS or RESP) aborts the access. No response is issued and no write strobe occurs on the reset edge or later.

## Timing
- Accept edge is T0, where req=1 and ready=1.
- Mapped access:
  - *_sel is high on cycles T0+1 … T0+1+WS.
  - mem_we, if a write, is high only on cycle T0+1+WS.
  - resp_valid is high on cycle T0+2+WS.
- Unmapped access: resp_valid is high on T0+1. No select is ever raised.
- Throughput: ready returns the cycle after resp_valid. Back-to-back mapped requests with WS=0 complete every 3 cycles.
- data_out and bus_err hold their values until the next response. They are only meaningful while resp_valid=1.
- Region read data must be valid combinationally or registered from sel, no later than the final ACCESS cycle.

## Configuration
- MEMCTRL_BUS_ERR_EN:
  - Defined: an unmapped access raises bus_err=1 together with resp_valid, with data_out=0. A write to the ROM region is also treated as an error: no rom_sel, direct to RESP, bus_err=1.
  - Undefined (legacy): bus_err is tied 0. Unmapped reads return 0. Unmapped writes are silently acknowledged. ROM writes proceed as normal accesses with mem_we=1.

## Test plan
- Read at 16'h0005 (ROM, WS=0), rom_rdata=32'hDEADBEEF:
  - rom_sel high on T0+1 only.
  - mem_addr=5.
  - resp_valid on T0+2 with data_out=32'hDEADBEEF.
  - bus_err=0.
- Write 32'h12345678 to 16'h0823 (RAM):
  - ram_sel and mem_we high on T0+1.
  - mem_addr=11'h023, mem_wdata=32'h12345678.
  - resp_valid on T0+2, data_out=0.
- Read 16'h0021 (I/O, WS=1), io_rdata=32'hA5:
  - io_sel high on T0+1 and T0+2.
  - resp_valid on T0+3 with data_out=32'hA5.
- Read 16'h4000 (unmapped):
  - No selects.
  - resp_valid on T0+1 with data_out=0.
  - bus_err=1 with MEMCTRL_BUS_ERR_EN, 0 without.
- Set IO_WS=3 and start an I/O write. Assert reset on T0+2:
  - mem_we never asserts.
  - No resp_valid.
  - ready=1 on the cycle after reset.
- Hold req high continuously with alternating ROM/RAM reads (WS=0):
  - Responses arrive every 3 cycles.
  - ready is low during ACCESS and RESP.
  - No request is lost or duplicated.
